// File: rtl/fwnoc_pkg.sv
// Shared fwnoc header layout, field helpers and NI state encodings.
// Optional destination filtering is enabled with FWNOC_NI_DST_CHECK_EN.
package fwnoc_pkg;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned RSVD_W    = 8;
  localparam int unsigned DST_X_LSB = 28;
  localparam int unsigned DST_Y_LSB = 24;
  localparam int unsigned SRC_X_LSB = 20;
  localparam int unsigned SRC_Y_LSB = 16;
  localparam int unsigned LEN_LSB   = 0;

  // Field order matches the LSB positions above, MSB first.
  typedef struct packed {
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;
    logic [RSVD_W-1:0]  rsvd;
    logic [LEN_W-1:0]   len;
  } hdr_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HDR  = 2'd1,
    T_PLD  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HDR  = 2'd0,
    R_PLD  = 2'd1
`ifdef FWNOC_NI_DST_CHECK_EN
    , R_DROP = 2'd2
`endif
  } rx_state_t;

  function automatic logic [FLIT_W-1:0] hdr_build(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [LEN_W-1:0]   len
  );
    hdr_t h;
    h.dst_x = dst_x;
    h.dst_y = dst_y;
    h.src_x = src_x;
    h.src_y = src_y;
    h.rsvd  = '0;
    h.len   = len;
    return FLIT_W'(h);
  endfunction

  function automatic logic [COORD_W-1:0] hdr_dst_x(input logic [FLIT_W-1:0] f);
    return f[DST_X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] hdr_dst_y(input logic [FLIT_W-1:0] f);
    return f[DST_Y_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] hdr_src_x(input logic [FLIT_W-1:0] f);
    return f[SRC_X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] hdr_src_y(input logic [FLIT_W-1:0] f);
    return f[SRC_Y_LSB +: COORD_W];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [FLIT_W-1:0] f);
    return f[LEN_LSB +: LEN_W];
  endfunction

endpackage

// File: rtl/fwnoc_ni_rx.sv
// RX half of the fwnoc NI: parses and strips the header, forwards payload to the host.
// With FWNOC_NI_DST_CHECK_EN, packets for a foreign node are drained and flagged on rx_err.
module fwnoc_ni_rx
  import fwnoc_pkg::*;
`ifdef FWNOC_NI_DST_CHECK_EN
#(
  parameter int unsigned X_ID = 0,
  parameter int unsigned Y_ID = 0
)
`endif
(
  input  logic               clock,
  input  logic               reset,
  input  logic               noc_i_valid,
  output logic               noc_i_ready,
  input  logic [FLIT_W-1:0]  noc_i_dat,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FLIT_W-1:0]  rx_dat,
  output logic               rx_last,
  output logic [COORD_W-1:0] rx_src_x,
  output logic [COORD_W-1:0] rx_src_y,
  output logic               rx_err
);

  rx_state_t        state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic             hdr_acc;
  logic             beat_xfer;
  logic             src_en;

  assign hdr_acc   = (state_q == R_HDR) && noc_i_valid;
  assign beat_xfer = (state_q != R_HDR) && noc_i_valid && noc_i_ready;

`ifdef FWNOC_NI_DST_CHECK_EN
  logic fwd;
  assign fwd    = (hdr_dst_x(noc_i_dat) == COORD_W'(X_ID)) &&
                  (hdr_dst_y(noc_i_dat) == COORD_W'(Y_ID));
  assign src_en = hdr_acc && fwd;

  always_ff @(posedge clock) begin
    if (reset) rx_err <= 1'b0;
    else       rx_err <= hdr_acc && !fwd;
  end
`else
  assign src_en = hdr_acc;
  assign rx_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= R_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_HDR: if (noc_i_valid) begin
`ifdef FWNOC_NI_DST_CHECK_EN
        state_d = fwd ? R_PLD : R_DROP;
`else
        state_d = R_PLD;
`endif
      end
      R_PLD:  if (beat_xfer && cnt_q == '0) state_d = R_HDR;
`ifdef FWNOC_NI_DST_CHECK_EN
      R_DROP: if (beat_xfer && cnt_q == '0) state_d = R_HDR;
`endif
      default: state_d = R_HDR;
    endcase
  end

  // Payload is a straight pass-through; the header flit is never forwarded.
  always_comb begin
    noc_i_ready = 1'b0;
    rx_valid    = 1'b0;
    rx_dat      = '0;
    rx_last     = 1'b0;
    if (!reset) begin
      case (state_q)
        R_HDR: noc_i_ready = 1'b1;
        R_PLD: begin
          rx_valid    = noc_i_valid;
          rx_dat      = noc_i_dat;
          noc_i_ready = rx_ready;
          rx_last     = (cnt_q == '0);
        end
`ifdef FWNOC_NI_DST_CHECK_EN
        R_DROP: noc_i_ready = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Counter exits at zero so len=255 never wraps inside a packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      rx_src_x <= '0;
      rx_src_y <= '0;
    end else begin
      if (hdr_acc)        cnt_q <= hdr_len(noc_i_dat);
      else if (beat_xfer) cnt_q <= cnt_q - LEN_W'(1);
      if (src_en) begin
        rx_src_x <= hdr_src_x(noc_i_dat);
        rx_src_y <= hdr_src_y(noc_i_dat);
      end
    end
  end

endmodule

// File: rtl/fwnoc_ni.sv
// fwnoc network interface top: inline TX packetiser plus the fwnoc_ni_rx depacketiser.
// FWNOC_NI_DST_CHECK_EN enables dropping of packets addressed to another node.
module fwnoc_ni
  import fwnoc_pkg::*;
#(
  parameter int unsigned X_ID = 0,
  parameter int unsigned Y_ID = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [FLIT_W-1:0]  tx_dat,
  input  logic [COORD_W-1:0] tx_dst_x,
  input  logic [COORD_W-1:0] tx_dst_y,
  input  logic [LEN_W-1:0]   tx_len,
  output logic               noc_o_valid,
  input  logic               noc_o_ready,
  output logic [FLIT_W-1:0]  noc_o_dat,
  input  logic               noc_i_valid,
  output logic               noc_i_ready,
  input  logic [FLIT_W-1:0]  noc_i_dat,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FLIT_W-1:0]  rx_dat,
  output logic               rx_last,
  output logic [COORD_W-1:0] rx_src_x,
  output logic [COORD_W-1:0] rx_src_y,
  output logic               rx_err
);

  tx_state_t        tx_q, tx_d;
  logic [FLIT_W-1:0] hdr_q;
  logic [LEN_W-1:0]  tx_cnt_q;
  logic              tx_xfer;

  assign tx_xfer = (tx_q == T_PLD) && tx_valid && noc_o_ready;

  always_ff @(posedge clock) begin
    if (reset) tx_q <= T_IDLE;
    else       tx_q <= tx_d;
  end

  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      T_IDLE:  if (tx_valid) tx_d = T_HDR;
      T_HDR:   if (noc_o_ready) tx_d = T_PLD;
      T_PLD:   if (tx_xfer && tx_cnt_q == '0) tx_d = T_IDLE;
      default: tx_d = T_IDLE;
    endcase
  end

  // Header comes from a register; payload beats pass straight through to the fabric.
  always_comb begin
    noc_o_valid = 1'b0;
    noc_o_dat   = '0;
    tx_ready    = 1'b0;
    if (!reset) begin
      case (tx_q)
        T_HDR: begin
          noc_o_valid = 1'b1;
          noc_o_dat   = hdr_q;
        end
        T_PLD: begin
          noc_o_valid = tx_valid;
          noc_o_dat   = tx_dat;
          tx_ready    = noc_o_ready;
        end
        default: ;
      endcase
    end
  end

  // Message fields are sampled only while idle; later changes have no effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_q    <= '0;
      tx_cnt_q <= '0;
    end else if (tx_q == T_IDLE && tx_valid) begin
      hdr_q    <= hdr_build(tx_dst_x, tx_dst_y, COORD_W'(X_ID), COORD_W'(Y_ID), tx_len);
      tx_cnt_q <= tx_len;
    end else if (tx_xfer) begin
      tx_cnt_q <= tx_cnt_q - LEN_W'(1);
    end
  end

  fwnoc_ni_rx
`ifdef FWNOC_NI_DST_CHECK_EN
  #(
    .X_ID(X_ID),
    .Y_ID(Y_ID)
  )
`endif
  u_rx (
    .clock       (clock),
    .reset       (reset),
    .noc_i_valid (noc_i_valid),
    .noc_i_ready (noc_i_ready),
    .noc_i_dat   (noc_i_dat),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_dat      (rx_dat),
    .rx_last     (rx_last),
    .rx_src_x    (rx_src_x),
    .rx_src_y    (rx_src_y),
    .rx_err      (rx_err)
  );

endmodule
